// File: rtl/sms_timing_ring.sv
// sms_timing_ring
// Programmable oscillator plus one-hot T-phase timing ring.
//
// A prescaler divides clk down to an oscillator (DIV clks per half period).
// Each T-phase spans one full oscillator period: osc low for DIV clks, then
// high for DIV clks. The ring advances on the edge where osc falls.
//
// Operating modes (mode):
//   00 run    : free-running ring
//   01 single : start launches one full ring sweep (busy high until wrap)
//   10 step   : each clk with step=1 advances one phase immediately
//   11 hold   : everything frozen
//
// Ports:
//   clk        master clock, rising edge
//   reset_n    synchronous active-low reset
//   enable     global run gate, 0 freezes all state
//   mode[1:0]  operating mode
//   start      single-cycle launch (mode 01)
//   step       manual advance (mode 10)
//   osc_c      oscillator output, pin C
//   osc_d      oscillator output, pin D (same flop as osc_c)
//   phase      one-hot ring, bit i = T-phase i
//   phase_idx  binary index of the active phase
//   cycle_end  one-clk pulse after the ring wraps to phase 0
//   busy       single-cycle sweep in progress
module sms_timing_ring #(
  parameter int DIV    = 2,
  parameter int PHASES = 10,
  parameter int IW     = $clog2(PHASES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              step,
  output logic              osc_c,
  output logic              osc_d,
  output logic [PHASES-1:0] phase,
  output logic [IW-1:0]     phase_idx,
  output logic              cycle_end,
  output logic              busy
);

  // Prescaler needs at least one bit even when DIV=1.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PHASES - 1);

  // Mode 11 (hold) needs no constant: it simply matches none of these.
  localparam logic [1:0] MODE_RUN    = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;

  logic [DW-1:0]     div_cnt_reg, div_cnt_next;
  logic              osc_reg, osc_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [PHASES-1:0] phase_reg, phase_next;
  logic              cycle_end_reg, cycle_end_next;
  logic              busy_reg, busy_next;

  logic run;   // prescaler counts this clk
  logic adv;   // ring advances this clk
  logic wrap;  // ring is at its last phase

  assign wrap = (idx_reg == IDX_LAST);

  always_comb begin
    div_cnt_next   = div_cnt_reg;
    osc_next       = osc_reg;
    idx_next       = idx_reg;
    busy_next      = busy_reg;
    cycle_end_next = 1'b0;
    run            = 1'b0;
    adv            = 1'b0;

    if (enable) begin
      // A launched single sweep owns the ring until it wraps, whatever the
      // mode input does in the meantime.
      if (busy_reg || mode == MODE_RUN) begin
        run = 1'b1;
      end else if (mode == MODE_SINGLE && start) begin
        div_cnt_next = '0;
        osc_next     = 1'b0;
        idx_next     = '0;
        busy_next    = 1'b1;
      end else if (mode == MODE_STEP && step) begin
        // Manual step restarts the oscillator at the beginning of the phase.
        adv          = 1'b1;
        div_cnt_next = '0;
        osc_next     = 1'b0;
      end
    end

    if (run) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
        osc_next     = ~osc_reg;
        // Falling edge of osc closes the current phase.
        if (osc_reg) begin
          adv = 1'b1;
        end
      end else begin
        div_cnt_next = div_cnt_reg + DW'(1);
      end
    end

    if (adv) begin
      if (wrap) begin
        idx_next       = '0;
        cycle_end_next = 1'b1;
        busy_next      = 1'b0;
      end else begin
        idx_next = idx_reg + IW'(1);
      end
    end
  end

  // One-hot decode of the next index keeps phase and phase_idx consistent.
  generate
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
      assign phase_next[gi] = (idx_next == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_reg   <= '0;
      osc_reg       <= 1'b0;
      idx_reg       <= '0;
      phase_reg     <= PHASES'(1);
      cycle_end_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      div_cnt_reg   <= div_cnt_next;
      osc_reg       <= osc_next;
      idx_reg       <= idx_next;
      phase_reg     <= phase_next;
      cycle_end_reg <= cycle_end_next;
      busy_reg      <= busy_next;
    end
  end

  assign osc_c     = osc_reg;
  assign osc_d     = osc_reg;
  assign phase     = phase_reg;
  assign phase_idx = idx_reg;
  assign cycle_end = cycle_end_reg;
  assign busy      = busy_reg;

endmodule

// File: doc/sms_timing_ring.md
Name: sms_timing_ring

Overview:
- Parametrised successor to the fixed 1 MC oscillator card.
- Divides the simulation master clock into a programmable-rate oscillator output, then drives a PHASES-stage one-hot timing ring that produces the 1620-style T-phase gates.
- Three operating modes: free-run, single memory cycle, and manual single-step (maintenance panel).
- Sits between the clock source and the core timing/trigger cards.

Parameters:
DIV, 2, master clk cycles per oscillator half-period (legal: >=1)
PHASES, 10, number of ring stages per cycle (legal: >=2)
IW, $clog2(PHASES), width of phase_idx

Ports:
clk  input  1  master clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
enable  input  1  global run gate; 0 freezes all state
mode  input  2  00 run, 01 single-cycle, 10 step, 11 hold
start  input  1  single-cycle launch pulse (mode 01 only)
step  input  1  manual advance pulse (mode 10 only)
osc_c  output  1  oscillator output, pin C
osc_d  output  1  oscillator output, pin D (identical to osc_c)
phase  output  PHASES  one-hot ring; bit i = T-phase i active
phase_idx  output  IW  binary index of the active phase
cycle_end  output  1  one-clk pulse on wrap PHASES-1 -> 0
busy  output  1  single-cycle ring in progress

Behaviour:
- Reset (reset_n=0 at an edge): osc=0, div_cnt=0, phase_idx=0, phase=1, cycle_end=0, busy=0. Reset overrides every other input.
- All outputs are registered. osc_c == osc_d on every cycle.
- Active condition (act): enable=1 AND (mode==00 OR busy=1).
- Prescaler, at each edge with act=1:
  - div_cnt==DIV-1: div_cnt<=0 and osc toggles.
  - otherwise: div_cnt++.
- Phase timing:
  - Each phase lasts exactly 2*DIV clks: osc low for the first DIV, high for the second.
  - The phase advances on the edge where osc toggles 1->0.
  - From reset, with act held, phase_idx becomes 1 at edge 2*DIV.
- Advance: phase_idx <= (phase_idx==PHASES-1) ? 0 : phase_idx+1, and phase stays one-hot and consistent with phase_idx. cycle_end=1 only during the clk following the edge on which idx wrapped to 0.
- enable=0: nothing changes (div_cnt, osc, phase, busy all hold). cycle_end=0.
- Mode 11, or any mode other than 00 with busy=0: everything holds as for enable=0.
- SINGLE (mode 01):
  - start=1 and enable=1 and busy=0: phase_idx<=0, div_cnt<=0, osc<=0, busy<=1.
  - The ring then runs exactly PHASES phases (PHASES*2*DIV clks).
  - On the wrap edge: busy<=0 and cycle_end pulses. The ring is left at phase 0, osc=0, div_cnt=0.
  - start while busy=1 is ignored.
  - Once busy=1, the ring runs to completion regardless of later mode changes; enable=0 still freezes it.
- STEP (mode 10, busy=0): each clk with step=1 and enable=1:
  - phase advances immediately by one; cycle_end pulses on wrap.
  - div_cnt<=0 and osc<=0.
  - A step held for N clks advances N phases; edge detection is the panel logic's job.
- Mode switch out of 00 mid-run: freezes at the current point. Re-entering 00 resumes from the frozen point without a phase jump.
- start in modes other than 01, and step in modes other than 10, are ignored.
- Simultaneous start and step: the current mode decides which one acts.

Test Plan:
- Reset, enable=1, mode=00, DIV=2, PHASES=10:
  - osc pattern is 0,0,1,1 repeating.
  - phase_idx=1 after edge 4, =9 after edge 36, =0 after edge 40.
  - cycle_end high for exactly the clk after edge 40.
  - osc_c==osc_d throughout.
- Mode 00, drop enable for 5 clks at idx=3 mid-phase: all outputs hold for 5 clks. On resume, idx 4 is reached 5 clks later than nominal.
- Mode 01, start pulse:
  - busy high for 40 clks; idx sweeps 0..9 then returns to 0.
  - single cycle_end pulse, then everything holds. A second start while busy has no effect.
- Mode 01, change mode to 10 while busy at idx=5: the ring still completes to idx 0 and busy clears.
- Mode 10, 12 single-clk step pulses from idx 0: idx ends at 2, cycle_end pulses once (on the 10th step), osc stays 0.
- reset_n=0 for one clk mid single-cycle (idx=6, busy=1): next cycle idx=0, busy=0, osc=0, no cycle_end. DIV=1 run: osc toggles every clk and the phase advances every 2 clks.
